// File: rtl/cook_pkg.sv
// Shared types and constants for the microwave cook sequencer.
package cook_pkg;

  // FSM states; the encodings are visible on the debug state port.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    COOKING = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } cook_state_t;

  // One BCD digit.
  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_UNITS = 4'd9;
  localparam bcd_t BCD_MAX_TENS  = 4'd5;

  localparam int         KEY_COUNT  = 10;
  localparam logic [3:0] FULL_POWER = 4'd10;

  // Highest pressed digit wins when several keys are down together.
  function automatic bcd_t key_digit(input logic [KEY_COUNT-1:0] k);
    bcd_t d;
    d = '0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (k[i]) d = bcd_t'(i);
    end
    return d;
  endfunction

  // Power setting 1..9 is used as-is; anything else means full power.
  function automatic logic [3:0] power_level(input logic [3:0] p);
    return ((p >= 4'd1) && (p <= 4'd9)) ? p : FULL_POWER;
  endfunction

endpackage

// File: rtl/bcd_time_down.sv
// Three-digit BCD time register (M:SS) with keypad shift-in,
// countdown with borrow, and zero / one-second detection.
module bcd_time_down
  import cook_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic zero_en,
  input  logic shift_en,
  input  bcd_t digit,
  input  logic dec_en,
  output bcd_t minutes,
  output bcd_t tens_sec,
  output bcd_t units_sec,
  output logic is_zero,
  output logic is_one
);

  // Time register: clear/zero first, then digit shift, then one-second decrement.
  // NOTE: sequential state uses non-blocking assignments so every digit reads
  // the old value of its neighbour during the shift and borrow chain.
  always_ff @(posedge clk) begin
    if (clear || zero_en) begin
      minutes   <= '0;
      tens_sec  <= '0;
      units_sec <= '0;
    end else if (shift_en) begin
      minutes   <= tens_sec;
      tens_sec  <= units_sec;
      units_sec <= digit;
    end else if (dec_en) begin
      if (units_sec != 4'd0) begin
        units_sec <= units_sec - 4'd1;
      end else begin
        units_sec <= BCD_MAX_UNITS;
        if (tens_sec != 4'd0) begin
          tens_sec <= tens_sec - 4'd1;
        end else begin
          tens_sec <= BCD_MAX_TENS;
          minutes  <= minutes - 4'd1;
        end
      end
    end
  end

  assign is_zero = (minutes == 4'd0) && (tens_sec == 4'd0) && (units_sec == 4'd0);
  assign is_one  = (minutes == 4'd0) && (tens_sec == 4'd0) && (units_sec == 4'd1);

endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: keypad digit entry, START/STOP/door handling,
// 1 s tick divider, BCD countdown and registered magnetron / beep outputs.
// Optional feature macro POWER_LEVEL_EN adds a power[3:0] input that duty-
// cycles the magnetron over a 10 s window; without it the magnetron is
// simply on while cooking.
module cook_sequencer
  import cook_pkg::*;
#(
  parameter int TICK_DIV  = 100,
  parameter int BEEP_SECS = 3
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [KEY_COUNT-1:0] keys,
  input  logic                 start_n,
  input  logic                 stop_n,
  input  logic                 closed_door,
`ifdef POWER_LEVEL_EN
  input  logic [3:0]           power,
`endif
  output logic                 magnetron,
  output logic [3:0]           minutes,
  output logic [3:0]           tens_sec,
  output logic [3:0]           units_sec,
  output logic                 done_beep,
  output logic [2:0]           state
);

  localparam int                TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [3:0]        BEEP_LAST = 4'(BEEP_SECS - 1);

  logic [KEY_COUNT-1:0] keys_q;
  logic                 start_q;
  logic                 stop_q;
  logic                 key_evt;
  logic                 start_evt;
  logic                 stop_evt;
  bcd_t                 digit;

  cook_state_t          state_q;
  cook_state_t          state_next;
  logic [TICK_W-1:0]    tick_cnt;
  logic                 tick;
  logic                 tick_run;
  logic                 start_cook;
  logic                 shift_en;
  logic                 dec_en;
  logic                 zero_en;
  logic [3:0]           beep_cnt;
  logic [3:0]           beep_cnt_next;
  logic                 mag_next;
  logic                 is_zero;
  logic                 is_one;
  logic                 time_ok;

  // Button/keypad history for edge detection; buttons idle released (high).
  always_ff @(posedge clk) begin
    if (clear) begin
      keys_q  <= '0;
      start_q <= 1'b1;
      stop_q  <= 1'b1;
    end else begin
      keys_q  <= keys;
      start_q <= start_n;
      stop_q  <= stop_n;
    end
  end

  assign key_evt   = (keys != '0) && (keys_q == '0);
  assign start_evt = start_q && !start_n;
  assign stop_evt  = stop_q && !stop_n;
  assign digit     = key_digit(keys);

  bcd_time_down u_time (
    .clk       (clk),
    .clear     (clear),
    .zero_en   (zero_en),
    .shift_en  (shift_en),
    .digit     (digit),
    .dec_en    (dec_en),
    .minutes   (minutes),
    .tens_sec  (tens_sec),
    .units_sec (units_sec),
    .is_zero   (is_zero),
    .is_one    (is_one)
  );

  assign time_ok = !is_zero && (tens_sec <= BCD_MAX_TENS);
  assign tick    = (tick_cnt == TICK_LAST);

  // Next-state and datapath controls; events are tested in priority order
  // stop > door open > start > key within each state.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next    = state_q;
    shift_en      = 1'b0;
    dec_en        = 1'b0;
    zero_en       = 1'b0;
    tick_run      = 1'b0;
    start_cook    = 1'b0;
    beep_cnt_next = beep_cnt;
    case (state_q)
      IDLE: begin
        if (key_evt) begin
          shift_en   = 1'b1;
          state_next = ENTRY;
        end
      end
      ENTRY: begin
        if (stop_evt) begin
          zero_en    = 1'b1;
          state_next = IDLE;
        end else if (start_evt && closed_door && time_ok) begin
          start_cook = 1'b1;
          state_next = COOKING;
        end else if (key_evt) begin
          shift_en = 1'b1;
        end
      end
      COOKING: begin
        if (stop_evt || !closed_door) begin
          state_next = PAUSED;
        end else begin
          tick_run = 1'b1;
          if (tick) begin
            dec_en = 1'b1;
            if (is_one) begin
              state_next    = DONE;
              beep_cnt_next = '0;
            end
          end
        end
      end
      PAUSED: begin
        if (stop_evt) begin
          zero_en    = 1'b1;
          state_next = IDLE;
        end else if (start_evt && closed_door && time_ok) begin
          start_cook = 1'b1;
          state_next = COOKING;
        end
      end
      DONE: begin
        if (stop_evt || !closed_door || key_evt) begin
          state_next = IDLE;
        end else begin
          tick_run = 1'b1;
          if (tick) begin
            if (beep_cnt == BEEP_LAST) state_next = IDLE;
            else                       beep_cnt_next = beep_cnt + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Tick divider: restarts on a fresh start from ENTRY; a resume from PAUSED
  // keeps the partial second that was already counted before the pause.
  always_ff @(posedge clk) begin
    if (clear) begin
      tick_cnt <= '0;
    end else if (start_cook && (state_q == ENTRY)) begin
      tick_cnt <= '0;
    end else if (tick_run) begin
      tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
    end
  end

`ifdef POWER_LEVEL_EN
  logic [3:0] pwr_q;
  logic [3:0] pwr_next;
  logic [3:0] win_q;
  logic [3:0] win_next;

  // Power window: latch the level on every start, step the 0..9 window on cooking ticks.
  always_comb begin
    pwr_next = pwr_q;
    win_next = win_q;
    if (start_cook) begin
      pwr_next = power_level(power);
      win_next = '0;
    end else if ((state_q == COOKING) && (state_next == COOKING) && tick) begin
      win_next = (win_q == BCD_MAX_UNITS) ? 4'd0 : win_q + 4'd1;
    end
  end

  // Power window registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      pwr_q <= '0;
      win_q <= '0;
    end else begin
      pwr_q <= pwr_next;
      win_q <= win_next;
    end
  end

  assign mag_next = (state_next == COOKING) && (win_next < pwr_next);
`else
  assign mag_next = (state_next == COOKING);
`endif

  // State register and registered outputs, all cleared by the CLEAR button.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      magnetron <= 1'b0;
      done_beep <= 1'b0;
      beep_cnt  <= '0;
    end else begin
      state_q   <= state_next;
      magnetron <= mag_next;
      done_beep <= (state_next == DONE);
      beep_cnt  <= beep_cnt_next;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Self-checking bench for cook_sequencer: directed scenarios followed by a
// randomized phase, every cycle compared against a seconds-based model.
module tb_cook_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int BEEP_SECS = 3;

  localparam int S_IDLE   = 0;
  localparam int S_ENTRY  = 1;
  localparam int S_COOK   = 2;
  localparam int S_PAUSED = 3;
  localparam int S_DONE   = 4;

  logic       clk = 1'b0;
  logic       clear;
  logic [9:0] keys;
  logic       start_n;
  logic       stop_n;
  logic       closed_door;
`ifdef POWER_LEVEL_EN
  logic [3:0] power;
`endif
  logic       magnetron;
  logic [3:0] minutes;
  logic [3:0] tens_sec;
  logic [3:0] units_sec;
  logic       done_beep;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: time kept as three digits while entering, handled as whole seconds when cooking.
  int         m_state, m_min, m_ten, m_unit, m_phase, m_beep_ticks, m_win, m_p;
  logic [9:0] p_keys;
  logic       p_start, p_stop;

  cook_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .BEEP_SECS (BEEP_SECS)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .keys        (keys),
    .start_n     (start_n),
    .stop_n      (stop_n),
    .closed_door (closed_door),
`ifdef POWER_LEVEL_EN
    .power       (power),
`endif
    .magnetron   (magnetron),
    .minutes     (minutes),
    .tens_sec    (tens_sec),
    .units_sec   (units_sec),
    .done_beep   (done_beep),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic begin_cook();
    m_win = 0;
`ifdef POWER_LEVEL_EN
    m_p = ((power >= 1) && (power <= 9)) ? int'(power) : 10;
`else
    m_p = 10;
`endif
  endtask

  task automatic model_step();
    bit kev, sev, pev, ok;
    int dg, secs;
    if (clear) begin
      m_state = S_IDLE; m_min = 0; m_ten = 0; m_unit = 0;
      m_phase = 0; m_beep_ticks = 0; m_win = 0; m_p = 10;
      p_keys = '0; p_start = 1'b1; p_stop = 1'b1;
      return;
    end
    kev = (keys != 0) && (p_keys == 0);
    sev = p_start && !start_n;
    pev = p_stop && !stop_n;
    p_keys = keys; p_start = start_n; p_stop = stop_n;
    dg = 0;
    for (int i = 0; i < 10; i++) if (keys[i]) dg = i;
    ok = ((m_min + m_ten + m_unit) != 0) && (m_ten <= 5);
    case (m_state)
      S_IDLE: if (kev) begin
        m_min = m_ten; m_ten = m_unit; m_unit = dg; m_state = S_ENTRY;
      end
      S_ENTRY: begin
        if (pev) begin
          m_min = 0; m_ten = 0; m_unit = 0; m_state = S_IDLE;
        end else if (sev && closed_door && ok) begin
          m_state = S_COOK; m_phase = 0; begin_cook();
        end else if (kev) begin
          m_min = m_ten; m_ten = m_unit; m_unit = dg;
        end
      end
      S_COOK: begin
        if (pev || !closed_door) begin
          m_state = S_PAUSED;
        end else begin
          m_phase++;
          if (m_phase == TICK_DIV) begin
            m_phase = 0;
            secs = m_min * 60 + m_ten * 10 + m_unit - 1;
            m_min = secs / 60; m_ten = (secs % 60) / 10; m_unit = secs % 10;
            m_win++;
            if (secs == 0) begin
              m_state = S_DONE; m_beep_ticks = 0;
            end
          end
        end
      end
      S_PAUSED: begin
        if (pev) begin
          m_min = 0; m_ten = 0; m_unit = 0; m_state = S_IDLE;
        end else if (sev && closed_door && ok) begin
          m_state = S_COOK; begin_cook();
        end
      end
      S_DONE: begin
        if (pev || !closed_door || kev) begin
          m_state = S_IDLE;
        end else begin
          m_phase++;
          if (m_phase == TICK_DIV) begin
            m_phase = 0;
            m_beep_ticks++;
            if (m_beep_ticks == BEEP_SECS) m_state = S_IDLE;
          end
        end
      end
      default: m_state = S_IDLE;
    endcase
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("state", state, m_state);
    check("minutes", minutes, m_min);
    check("tens_sec", tens_sec, m_ten);
    check("units_sec", units_sec, m_unit);
    check("magnetron", magnetron, ((m_state == S_COOK) && ((m_win % 10) < m_p)) ? 1 : 0);
    check("done_beep", done_beep, (m_state == S_DONE) ? 1 : 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press_key(input int d);
    keys = '0; keys[d] = 1'b1; cycle();
    keys = '0; cycle();
  endtask

  task automatic pulse_start();
    start_n = 1'b0; cycle();
    start_n = 1'b1; cycle();
  endtask

  task automatic pulse_stop();
    stop_n = 1'b0; cycle();
    stop_n = 1'b1; cycle();
  endtask

  task automatic check_time(input string tag, input int mm, input int t, input int u);
    check(tag, {minutes, tens_sec, units_sec}, {mm[3:0], t[3:0], u[3:0]});
  endtask

  initial begin
    clear = 1'b1; keys = '0; start_n = 1'b1; stop_n = 1'b1; closed_door = 1'b1;
`ifdef POWER_LEVEL_EN
    power = 4'd10;
`endif
    run(2);
    check("reset_state", state, S_IDLE);
    check("reset_outputs", {magnetron, done_beep, minutes, tens_sec, units_sec}, 0);
    clear = 1'b0; cycle();

    // 1: enter 1:30, start, first decrement 4 cycles after the start edge.
    press_key(1); press_key(3); press_key(0);
    check("entry_state", state, S_ENTRY);
    check_time("entry_130", 1, 3, 0);
    pulse_start();
    check("start_mag", magnetron, 1);
    check("start_state", state, S_COOK);
    run(2);
    check_time("pre_tick_130", 1, 3, 0);
    run(1);
    check_time("tick_129", 1, 2, 9);

    // 2: 0:02 runs out; DONE with beep for three seconds.
    pulse_stop(); pulse_stop();
    check("stop_idle", state, S_IDLE);
    check_time("stop_clear", 0, 0, 0);
    press_key(2);
    pulse_start(); run(3);
    check_time("tick_001", 0, 0, 1);
    run(3);
    check("pre_done_mag", magnetron, 1);
    run(1);
    check_time("done_000", 0, 0, 0);
    check("done_mag", magnetron, 0);
    check("done_beep_on", done_beep, 1);
    check("done_state", state, S_DONE);
    run(11);
    check("beep_held", done_beep, 1);
    run(1);
    check("beep_end_state", state, S_IDLE);
    check("beep_end", done_beep, 0);

    // 3: door opens mid-cook; resume keeps the partial second.
    press_key(4); press_key(5);
    pulse_start(); run(5);
    check_time("cook_044", 0, 4, 4);
    closed_door = 1'b0; cycle();
    check("door_pause", state, S_PAUSED);
    check("door_mag", magnetron, 0);
    run(5);
    check_time("paused_hold", 0, 4, 4);
    closed_door = 1'b1; cycle();
    pulse_start();
    check("resume_state", state, S_COOK);
    check_time("resume_hold", 0, 4, 4);
    run(1);
    check_time("resume_tick", 0, 4, 3);

    // 4: invalid tens blocks start; 4th digit drops the oldest.
    pulse_stop(); pulse_stop();
    press_key(7); press_key(0);
    pulse_start();
    check("bad_start_state", state, S_ENTRY);
    check("bad_start_mag", magnetron, 0);
    pulse_stop();
    check_time("entry_stop_clear", 0, 0, 0);
    press_key(9); press_key(9); press_key(9); press_key(5);
    check_time("shift_995", 9, 9, 5);

    // 5: start and stop together; key aborts DONE; clear mid-cook.
    start_n = 1'b0; stop_n = 1'b0; cycle();
    start_n = 1'b1; stop_n = 1'b1; cycle();
    check("start_stop_idle", state, S_IDLE);
    check_time("start_stop_clear", 0, 0, 0);
    press_key(1); pulse_start(); run(3);
    check("short_done", state, S_DONE);
    press_key(5);
    check("key_abort_done", state, S_IDLE);
    check_time("key_not_entered", 0, 0, 0);
    check("key_abort_beep", done_beep, 0);
    press_key(3); press_key(0); pulse_start(); run(6);
    clear = 1'b1; cycle();
    check("clear_all", {state, magnetron, done_beep, minutes, tens_sec, units_sec}, 0);
    clear = 1'b0; cycle();

`ifdef POWER_LEVEL_EN
    // 6: power 3 gives 3 s on / 7 s off; power 0 is full power.
    power = 4'd3;
    press_key(2); press_key(0); pulse_start();
    check("p3_on", magnetron, 1);
    run(10);
    check("p3_on_end", magnetron, 1);
    run(1);
    check("p3_off", magnetron, 0);
    run(27);
    check("p3_off_end", magnetron, 0);
    run(1);
    check("p3_on_again", magnetron, 1);
    pulse_stop(); pulse_stop();
    power = 4'd0;
    press_key(2); press_key(0); pulse_start(); run(40);
    check("p0_full", magnetron, 1);
    pulse_stop(); pulse_stop();
`endif

    // Randomized phase against the model.
    for (int c = 0; c < 1500; c++) begin
      if (keys != 0) begin
        if ($urandom_range(0, 3) != 0) keys = '0;
      end else if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 7) == 0) keys = 10'($urandom_range(1, 1023));
        else begin
          keys = '0; keys[$urandom_range(0, 1)] = 1'b1;
        end
      end
      start_n     = (start_n == 1'b0) ? 1'b1 : ($urandom_range(0, 14) != 0);
      stop_n      = (stop_n == 1'b0) ? 1'b1 : ($urandom_range(0, 79) != 0);
      closed_door = ($urandom_range(0, 59) != 0);
      clear       = ($urandom_range(0, 399) == 0);
`ifdef POWER_LEVEL_EN
      power       = 4'($urandom_range(0, 15));
`endif
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
